// File: rtl/rf_pkg.sv
// ============================================================================
// Module : rf_pkg
// Shared defaults and constants for the scoreboarded register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rf_pkg;
  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 32;
  localparam int AW_DEF       = $clog2(NREGS_DEF);
  localparam int REG_ZERO     = 0;
  // 1: load writeback (port 1) wins a same-address collision
  localparam bit WR_PRIO_LOAD = 1'b1;
endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module : rf_read_port
// One combinational read mux with x0 masking; same-cycle write-through
// forwarding when REGFILE_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [NREGS*XLEN-1:0] mem_flat,
  input  logic [NREGS-1:0]      busy,
  input  logic [AW-1:0]         raddr,
  input  logic                  wr0,
  input  logic [AW-1:0]         waddr0,
  input  logic [XLEN-1:0]       wdata0,
  input  logic                  wr1,
  input  logic [AW-1:0]         waddr1,
  input  logic [XLEN-1:0]       wdata1,
  output logic [XLEN-1:0]       rdata,
  output logic                  rbusy
);

  logic            w_zero;
  logic [XLEN-1:0] w_arr_data;
  logic            w_arr_busy;

  assign w_zero     = (raddr == AW'(REG_ZERO));
  assign w_arr_data = mem_flat[raddr*XLEN +: XLEN];
  assign w_arr_busy = busy[raddr];

`ifdef REGFILE_BYPASS_EN
  logic w_hit0, w_hit1;

  assign w_hit0 = wr0 && (waddr0 == raddr);
  assign w_hit1 = wr1 && (waddr1 == raddr);

  always_comb begin
    rdata = w_arr_data;
    rbusy = w_arr_busy;
    if (w_hit1 && (WR_PRIO_LOAD || !w_hit0)) begin
      rdata = wdata1;
    end else if (w_hit0) begin
      rdata = wdata0;
    end
    // a retiring producer no longer blocks the reader
    if (w_hit0 || w_hit1) begin
      rbusy = 1'b0;
    end
    if (w_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{wr0, waddr0, wdata0, wr1, waddr1, wdata1};

  always_comb begin
    rdata = w_arr_data;
    rbusy = w_arr_busy;
    if (w_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module : regfile_sb
// NRP-read / 2-write register file with hardwired x0 and a per-register busy
// scoreboard. Optional write-through forwarding: define REGFILE_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_sb
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS),
  parameter int NRP   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                wr0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                wr1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]       r_mem [NREGS];
  logic [NREGS-1:0]      r_busy;
  logic [NREGS-1:0]      w_take0, w_take1, w_wb, w_iss;
  logic [NREGS*XLEN-1:0] w_mem_flat;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic w_hit0, w_hit1;

    assign w_hit0     = wr0 && (waddr0 == AW'(r)) && (r != REG_ZERO);
    assign w_hit1     = wr1 && (waddr1 == AW'(r)) && (r != REG_ZERO);
    assign w_take1[r] = w_hit1 && (WR_PRIO_LOAD || !w_hit0);
    assign w_take0[r] = w_hit0 && !w_take1[r];
    assign w_wb[r]    = w_hit0 || w_hit1;
    assign w_iss[r]   = iss_valid && (iss_rd == AW'(r)) && (r != REG_ZERO);
    assign w_mem_flat[r*XLEN +: XLEN] = r_mem[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_mem[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (w_take1[r]) begin
          r_mem[r] <= wdata1;
        end else if (w_take0[r]) begin
          r_mem[r] <= wdata0;
        end
      end
      if (flush) begin
        r_busy <= '0;
      end else begin
        // a newly issued producer owns rd even if an older one retires now
        for (int r = 0; r < NREGS; r++) begin
          if (w_iss[r]) begin
            r_busy[r] <= 1'b1;
          end else if (w_wb[r]) begin
            r_busy[r] <= 1'b0;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rport
    rf_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rport (
      .mem_flat (w_mem_flat),
      .busy     (r_busy),
      .raddr    (raddr[i*AW +: AW]),
      .wr0      (wr0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .wr1      (wr1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .rdata    (rdata[i*XLEN +: XLEN]),
      .rbusy    (rbusy[i])
    );
  end

  assign busy_vec = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module : tb_regfile_sb
// Self-checking bench for regfile_sb against an array-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRP   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                wr0, wr1, iss_valid, flush;
  logic [AW-1:0]       waddr0, waddr1, iss_rd;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [NREGS-1:0]    busy_vec;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wr0(wr0), .waddr0(waddr0), .wdata0(wdata0),
    .wr1(wr1), .waddr1(waddr1), .wdata1(wdata1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] m_mem  [NREGS];
  logic            m_busy [NREGS];

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1 && waddr1 == a) return wdata1;
    if (wr0 && waddr0 == a) return wdata0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wr1 && waddr1 == a) || (wr0 && waddr0 == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_bv();
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic void model_update();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (wr0 && waddr0 != 0) m_mem[waddr0] = wdata0;
      if (wr1 && waddr1 != 0) m_mem[waddr1] = wdata1;
      if (flush) begin
        for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      end else begin
        if (wr0) m_busy[waddr0] = 1'b0;
        if (wr1) m_busy[waddr1] = 1'b0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
    end
  endfunction

  task automatic idle();
    rst = 0; wr0 = 0; wr1 = 0; iss_valid = 0; flush = 0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    idle();
    raddr = '0;
    rst = 1; wr0 = 1; waddr0 = 5'd10; wdata0 = 32'hFFFF_FFFF;
    iss_valid = 1; iss_rd = 5'd3;
    tick();
    idle();
    for (int a = 0; a < NREGS; a++) begin
      raddr[0 +: AW]  = AW'(a);
      raddr[AW +: AW] = AW'(NREGS - 1 - a);
      @(negedge clk);
      for (int i = 0; i < NRP; i++) begin
        total++;
        if (rdata[i*XLEN +: XLEN] !== '0) begin
          bad++;
          $display("FAIL reset_rdata port=%0d addr=%0d got=%h want=0", i, raddr[i*AW +: AW], rdata[i*XLEN +: XLEN]);
        end
      end
      total++;
      if (rbusy !== '0 || busy_vec !== '0) begin
        bad++;
        $display("FAIL reset_busy got rbusy=%b busy_vec=%h want 0/0", rbusy, busy_vec);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    idle();
    wr0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
    tick();
    idle();
    wr0 = 1; waddr0 = 5'd0; wdata0 = 32'h0000_1234;
    tick();
    idle();
    raddr[0 +: AW] = 5'd5; raddr[AW +: AW] = 5'd0;
    @(negedge clk);
    total++;
    if (rdata[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL wr_rd5 got=%h want=deadbeef", rdata[0 +: XLEN]);
    end
    total++;
    if (rdata[XLEN +: XLEN] !== 32'h0 || rbusy[1] !== 1'b0) begin
      bad++; $display("FAIL x0_read got=%h rbusy=%b want=0/0", rdata[XLEN +: XLEN], rbusy[1]);
    end
    tick();
  endtask

  task automatic test_collision();
    idle();
    wr0 = 1; waddr0 = 5'd7; wdata0 = 32'h1111_1111;
    wr1 = 1; waddr1 = 5'd7; wdata1 = 32'h2222_2222;
    tick();
    idle();
    raddr[0 +: AW] = 5'd7; raddr[AW +: AW] = 5'd5;
    @(negedge clk);
    total++;
    if (rdata[0 +: XLEN] !== 32'h2222_2222) begin
      bad++; $display("FAIL collision got=%h want=22222222", rdata[0 +: XLEN]);
    end
    total++;
    if (rdata[XLEN +: XLEN] !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL collision_other got=%h want=deadbeef", rdata[XLEN +: XLEN]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_rd = 5'd9;
    tick();
    idle();
    raddr[0 +: AW] = 5'd9;
    @(negedge clk);
    total++;
    if (busy_vec[9] !== 1'b1 || rbusy[0] !== 1'b1) begin
      bad++; $display("FAIL sb_set got busy_vec9=%b rbusy0=%b want 1/1", busy_vec[9], rbusy[0]);
    end
    tick();
    idle();
    wr1 = 1; waddr1 = 5'd9; wdata1 = 32'hA5A5_A5A5;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (busy_vec[9] !== 1'b0 || rbusy[0] !== 1'b0 || rdata[0 +: XLEN] !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL sb_clear got busy=%b rbusy=%b data=%h want 0/0/a5a5a5a5", busy_vec[9], rbusy[0], rdata[0 +: XLEN]);
    end
    tick();
    idle();
    iss_valid = 1; iss_rd = 5'd9; wr0 = 1; waddr0 = 5'd9; wdata0 = 32'h5A5A_5A5A;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (busy_vec[9] !== 1'b1 || rdata[0 +: XLEN] !== 32'h5A5A_5A5A) begin
      bad++; $display("FAIL sb_issue_wins got busy=%b data=%h want 1/5a5a5a5a", busy_vec[9], rdata[0 +: XLEN]);
    end
    tick();
  endtask

  task automatic test_flush_reset();
    idle();
    iss_valid = 1; iss_rd = 5'd3;
    tick();
    iss_rd = 5'd4;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (busy_vec !== 32'h0000_0218) begin
      bad++; $display("FAIL busy_multi got=%h want=00000218", busy_vec);
    end
    tick();
    flush = 1; iss_valid = 1; iss_rd = 5'd6;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (busy_vec !== '0) begin
      bad++; $display("FAIL flush got=%h want=0", busy_vec);
    end
    tick();
    iss_valid = 1; iss_rd = 5'd0;
    tick();
    idle();
    raddr[0 +: AW] = 5'd0;
    @(negedge clk);
    total++;
    if (busy_vec !== '0 || rbusy[0] !== 1'b0) begin
      bad++; $display("FAIL iss_x0 got busy_vec=%h rbusy0=%b want 0/0", busy_vec, rbusy[0]);
    end
    tick();
    wr0 = 1; waddr0 = 5'd10; wdata0 = 32'h1234_5678;
    tick();
    rst = 1; wr0 = 1; waddr0 = 5'd10; wdata0 = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = 5'd11;
    tick();
    idle();
    raddr[0 +: AW] = 5'd10; raddr[AW +: AW] = 5'd5;
    @(negedge clk);
    total++;
    if (rdata !== '0 || busy_vec !== '0) begin
      bad++; $display("FAIL rst_priority got rdata=%h busy_vec=%h want 0/0", rdata, busy_vec);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    wr0 = 1; waddr0 = 5'd12; wdata0 = 32'h0BAD_C0DE;
    tick();
    idle();
    iss_valid = 1; iss_rd = 5'd12;
    tick();
    idle();
    wr0 = 1; waddr0 = 5'd12; wdata0 = 32'hCAFE_F00D;
    raddr[0 +: AW] = 5'd12;
    @(negedge clk);
    total++;
`ifdef REGFILE_BYPASS_EN
    if (rdata[0 +: XLEN] !== 32'hCAFE_F00D || rbusy[0] !== 1'b0) begin
      bad++; $display("FAIL bypass_same got=%h rbusy=%b want cafef00d/0", rdata[0 +: XLEN], rbusy[0]);
    end
`else
    if (rdata[0 +: XLEN] !== 32'h0BAD_C0DE || rbusy[0] !== 1'b1) begin
      bad++; $display("FAIL bypass_same got=%h rbusy=%b want 0badc0de/1", rdata[0 +: XLEN], rbusy[0]);
    end
`endif
    tick();
    idle();
    @(negedge clk);
    total++;
    if (rdata[0 +: XLEN] !== 32'hCAFE_F00D || rbusy[0] !== 1'b0) begin
      bad++; $display("FAIL bypass_next got=%h rbusy=%b want cafef00d/0", rdata[0 +: XLEN], rbusy[0]);
    end
    tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      wr0       = $urandom_range(0, 1);
      wr1       = $urandom_range(0, 1);
      iss_valid = ($urandom_range(0, 2) == 0);
      waddr0    = rand_addr();
      waddr1    = rand_addr();
      iss_rd    = rand_addr();
      wdata0    = $urandom;
      wdata1    = $urandom;
      for (int i = 0; i < NRP; i++) raddr[i*AW +: AW] = rand_addr();
      @(negedge clk);
      for (int i = 0; i < NRP; i++) begin
        total++;
        if (rdata[i*XLEN +: XLEN] !== exp_rd(raddr[i*AW +: AW]) || rbusy[i] !== exp_rb(raddr[i*AW +: AW])) begin
          bad++;
          $display("FAIL rand_read n=%0d port=%0d addr=%0d got=%h/%b want=%h/%b", n, i, raddr[i*AW +: AW],
                   rdata[i*XLEN +: XLEN], rbusy[i], exp_rd(raddr[i*AW +: AW]), exp_rb(raddr[i*AW +: AW]));
        end
      end
      total++;
      if (busy_vec !== exp_bv()) begin
        bad++; $display("FAIL rand_busy_vec n=%0d got=%h want=%h", n, busy_vec, exp_bv());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    raddr = '0;
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_flush_reset();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
